// File: rtl/sa_pkg.sv
// Shared systolic-array package.
// Holds the feature-fetch FSM state enum and the default widths and hold
// length used by feature_fetch_ctrl.
package sa_pkg;

  localparam int FEAT_ADDRS_WIDTH_DEF    = 12;
  localparam int FEAT_COUNT_WIDTH_DEF    = 10;
  localparam int COUNTER_ROUND_WIDTH_DEF = 3;
  localparam int HOLD_CYCLES_DEF         = 16;

  typedef enum logic [1:0] {
    FF_IDLE       = 2'd0,
    FF_STREAM     = 2'd1,
    FF_PASS_END   = 2'd2,
    FF_FINAL_HOLD = 2'd3
  } feat_fetch_state_e;

endpackage

// File: rtl/counter.sv
// Generic up-counter with synchronous clear.
// Ports: clk_i clock, rst_ni sync active-low reset, clr_i clear (wins over
// en_i), en_i increment, cnt_o current count.
module counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [WIDTH-1:0] cnt_o
);

  always_ff @(posedge clk_i) begin
    if (!rst_ni)    cnt_o <= '0;
    else if (clr_i) cnt_o <= '0;
    else if (en_i)  cnt_o <= cnt_o + WIDTH'(1);
  end

endmodule

// File: rtl/feature_fetch_ctrl.sv
// Input-feature stream sequencer for the systolic array.
// Accepts a job descriptor (base, features per pass, weight rounds), issues
// one feature-buffer read per request, raises end_feature_o after each
// pass, repeats the stream per round, then holds end_feature_o for
// HOLD_CYCLES before pulsing done_o.
// Ports:
//   clk_i, rst_ni            clock, synchronous active-low reset
//   cfg_valid_i/cfg_ready_o  descriptor handshake
//   cfg_base_addrs_i         first feature address
//   cfg_num_features_i       features per pass
//   cfg_max_round_i          number of weight passes
//   cfg_stride_i             address stride (FEAT_FETCH_STRIDE_EN only)
//   rd_feature_ld_i, load_i  requests from the array controller
//   feat_rd_en_o/feat_addrs_o feature-buffer read
//   end_feature_o, round_o, busy_o, done_o  status (all registered)
// Build option: define FEAT_FETCH_STRIDE_EN to add cfg_stride_i; otherwise
// the stride is fixed at 1.
module feature_fetch_ctrl
  import sa_pkg::*;
#(
  parameter int FEAT_ADDRS_WIDTH    = FEAT_ADDRS_WIDTH_DEF,
  parameter int FEAT_COUNT_WIDTH    = FEAT_COUNT_WIDTH_DEF,
  parameter int COUNTER_ROUND_WIDTH = COUNTER_ROUND_WIDTH_DEF,
  parameter int HOLD_CYCLES         = HOLD_CYCLES_DEF
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           cfg_valid_i,
  output logic                           cfg_ready_o,
  input  logic [FEAT_ADDRS_WIDTH-1:0]    cfg_base_addrs_i,
  input  logic [FEAT_COUNT_WIDTH-1:0]    cfg_num_features_i,
  input  logic [COUNTER_ROUND_WIDTH-1:0] cfg_max_round_i,
`ifdef FEAT_FETCH_STRIDE_EN
  input  logic [FEAT_ADDRS_WIDTH-1:0]    cfg_stride_i,
`endif
  input  logic                           rd_feature_ld_i,
  input  logic                           load_i,
  output logic                           feat_rd_en_o,
  output logic [FEAT_ADDRS_WIDTH-1:0]    feat_addrs_o,
  output logic                           end_feature_o,
  output logic [COUNTER_ROUND_WIDTH-1:0] round_o,
  output logic                           busy_o,
  output logic                           done_o
);

  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
  localparam logic [HOLD_W-1:0]              HOLD_LAST = HOLD_W'(HOLD_CYCLES);
  localparam logic [FEAT_COUNT_WIDTH-1:0]    CNT_ONE   = FEAT_COUNT_WIDTH'(1);
  localparam logic [COUNTER_ROUND_WIDTH-1:0] RND_ONE   = COUNTER_ROUND_WIDTH'(1);

  feat_fetch_state_e state_q, state_d;

  logic [FEAT_ADDRS_WIDTH-1:0]    base_q, offset;
  logic [FEAT_COUNT_WIDTH-1:0]    num_q, idx;
  logic [COUNTER_ROUND_WIDTH-1:0] max_q, rnd;
  logic [HOLD_W-1:0]              hold;
`ifdef FEAT_FETCH_STRIDE_EN
  logic [FEAT_ADDRS_WIDTH-1:0]    stride_q;
`endif

  logic accept, degen, issue, last_idx, final_pass, pass_load, hold_done;
  logic rd_en_d, end_d, done_d;
  logic ready_q, busy_q, rd_en_q, end_q, done_q;
  logic [FEAT_ADDRS_WIDTH-1:0] addr_q;

  assign accept     = (state_q == FF_IDLE) && cfg_valid_i;
  assign degen      = (cfg_num_features_i == '0) || (cfg_max_round_i == '0);
  assign issue      = (state_q == FF_STREAM) && rd_feature_ld_i;
  assign last_idx   = (idx == num_q - CNT_ONE);
  assign final_pass = (rnd == max_q - RND_ONE);
  assign pass_load  = (state_q == FF_PASS_END) && load_i;
  assign hold_done  = (state_q == FF_FINAL_HOLD) && (hold == HOLD_LAST);

`ifdef FEAT_FETCH_STRIDE_EN
  assign offset = FEAT_ADDRS_WIDTH'(idx) * stride_q;
`else
  assign offset = FEAT_ADDRS_WIDTH'(idx);
`endif

  // Feature index: restarts on accept and at the start of every pass.
  counter #(.WIDTH(FEAT_COUNT_WIDTH)) u_idx_cnt (
    .clk_i(clk_i), .rst_ni(rst_ni), .clr_i(accept || pass_load),
    .en_i(issue), .cnt_o(idx)
  );

  // Round: cleared again on completion so IDLE reports round 0.
  counter #(.WIDTH(COUNTER_ROUND_WIDTH)) u_rnd_cnt (
    .clk_i(clk_i), .rst_ni(rst_ni), .clr_i(accept || hold_done),
    .en_i(pass_load), .cnt_o(rnd)
  );

  // Hold cycles spent in FINAL_HOLD; zero on entry.
  counter #(.WIDTH(HOLD_W)) u_hold_cnt (
    .clk_i(clk_i), .rst_ni(rst_ni), .clr_i(state_q != FF_FINAL_HOLD),
    .en_i(state_q == FF_FINAL_HOLD), .cnt_o(hold)
  );

  always_comb begin
    state_d = state_q;
    end_d   = 1'b0;
    done_d  = 1'b0;
    rd_en_d = issue;
    unique case (state_q)
      FF_IDLE: begin
        if (cfg_valid_i) begin
          if (degen) done_d  = 1'b1;
          else       state_d = FF_STREAM;
        end
      end
      FF_STREAM: begin
        if (issue && last_idx) state_d = final_pass ? FF_FINAL_HOLD : FF_PASS_END;
      end
      FF_PASS_END: begin
        // end_feature_o is computed from the current state, so it appears
        // one cycle after the last strobe and drops once load_i is seen.
        if (load_i) state_d = FF_STREAM;
        else        end_d   = 1'b1;
      end
      FF_FINAL_HOLD: begin
        if (hold_done) begin
          state_d = FF_IDLE;
          done_d  = 1'b1;
        end else begin
          end_d = 1'b1;
        end
      end
      default: state_d = FF_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= FF_IDLE;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
      rd_en_q  <= 1'b0;
      end_q    <= 1'b0;
      done_q   <= 1'b0;
      addr_q   <= '0;
      base_q   <= '0;
      num_q    <= '0;
      max_q    <= '0;
`ifdef FEAT_FETCH_STRIDE_EN
      stride_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      ready_q <= (state_d == FF_IDLE);
      busy_q  <= (state_d != FF_IDLE);
      rd_en_q <= rd_en_d;
      end_q   <= end_d;
      done_q  <= done_d;
      if (issue) addr_q <= base_q + offset;
      if (accept) begin
        base_q   <= cfg_base_addrs_i;
        num_q    <= cfg_num_features_i;
        max_q    <= cfg_max_round_i;
`ifdef FEAT_FETCH_STRIDE_EN
        stride_q <= cfg_stride_i;
`endif
      end
    end
  end

  assign cfg_ready_o   = ready_q;
  assign busy_o        = busy_q;
  assign feat_rd_en_o  = rd_en_q;
  assign feat_addrs_o  = addr_q;
  assign end_feature_o = end_q;
  assign done_o        = done_q;
  assign round_o       = rnd;

endmodule

// File: tb/tb_feature_fetch_ctrl.sv
module tb_feature_fetch_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        cfg_valid_i = 1'b0;
  logic        cfg_ready_o;
  logic [11:0] cfg_base_addrs_i = '0;
  logic [9:0]  cfg_num_features_i = '0;
  logic [2:0]  cfg_max_round_i = '0;
`ifdef FEAT_FETCH_STRIDE_EN
  logic [11:0] cfg_stride_i = 12'd1;
`endif
  logic        rd_feature_ld_i = 1'b0;
  logic        load_i = 1'b0;
  logic        feat_rd_en_o;
  logic [11:0] feat_addrs_o;
  logic        end_feature_o;
  logic [2:0]  round_o;
  logic        busy_o;
  logic        done_o;

  int ncmp = 0;
  int nfail = 0;

  always #5 clk_i = ~clk_i;

  feature_fetch_ctrl dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .cfg_valid_i(cfg_valid_i), .cfg_ready_o(cfg_ready_o),
    .cfg_base_addrs_i(cfg_base_addrs_i), .cfg_num_features_i(cfg_num_features_i),
    .cfg_max_round_i(cfg_max_round_i),
`ifdef FEAT_FETCH_STRIDE_EN
    .cfg_stride_i(cfg_stride_i),
`endif
    .rd_feature_ld_i(rd_feature_ld_i), .load_i(load_i),
    .feat_rd_en_o(feat_rd_en_o), .feat_addrs_o(feat_addrs_o),
    .end_feature_o(end_feature_o), .round_o(round_o),
    .busy_o(busy_o), .done_o(done_o)
  );

  // Inputs change and outputs are sampled 1 time unit after the active edge.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Issue a descriptor; returns after the accept edge with valid dropped.
  task automatic start_job(input logic [11:0] base, input logic [9:0] num,
                           input logic [2:0] rounds, input logic ld);
    cfg_base_addrs_i   = base;
    cfg_num_features_i = num;
    cfg_max_round_i    = rounds;
    rd_feature_ld_i    = ld;
    cfg_valid_i        = 1'b1;
    step();
    cfg_valid_i        = 1'b0;
  endtask

  // With rd_feature_ld_i high, expect n strobes at base, base+1, ...
  task automatic burst(input string tag, input logic [11:0] base, input int n,
                       input logic [2:0] rnd);
    logic [11:0] a;
    for (int i = 0; i < n; i++) begin
      step();
      a = base + 12'(i);
      chk({tag, "_rd_en"}, feat_rd_en_o, 1);
      chk({tag, "_addr"}, feat_addrs_o, a);
      chk({tag, "_end_lo"}, end_feature_o, 0);
      chk({tag, "_round"}, round_o, rnd);
    end
  endtask

  // 16 cycles of end_feature_o, then one-cycle done_o with busy_o falling.
  task automatic hold_and_done(input string tag);
    for (int i = 0; i < 16; i++) begin
      step();
      chk({tag, "_hold_end"}, end_feature_o, 1);
      chk({tag, "_hold_nodone"}, done_o, 0);
      chk({tag, "_hold_nord"}, feat_rd_en_o, 0);
    end
    step();
    chk({tag, "_done"}, done_o, 1);
    chk({tag, "_done_busy"}, busy_o, 0);
    chk({tag, "_done_end"}, end_feature_o, 0);
    chk({tag, "_done_ready"}, cfg_ready_o, 1);
    step();
    chk({tag, "_done_pulse"}, done_o, 0);
  endtask

  initial begin
    logic [5:0]  pat;
    logic [11:0] a;
    int          nstb;

    // ---- reset state
    step(); step();
    chk("rst_ready", cfg_ready_o, 0);
    chk("rst_rd_en", feat_rd_en_o, 0);
    chk("rst_addr", feat_addrs_o, 0);
    chk("rst_end", end_feature_o, 0);
    chk("rst_round", round_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    rst_ni = 1'b1;
    step();
    chk("idle_ready", cfg_ready_o, 1);
    chk("idle_busy", busy_o, 0);

    // ---- single pass, base 0x010, 4 features
    start_job(12'h010, 10'd4, 3'd1, 1'b1);
    chk("t1_busy", busy_o, 1);
    chk("t1_ready_lo", cfg_ready_o, 0);
    chk("t1_no_rd_yet", feat_rd_en_o, 0);
    burst("t1", 12'h010, 4, 3'd0);
    rd_feature_ld_i = 1'b0;
    hold_and_done("t1");

    // ---- three rounds of 3, load_i 5 cycles after end_feature_o
    start_job(12'h040, 10'd3, 3'd3, 1'b1);
    for (int r = 0; r < 3; r++) begin
      if (r == 0) begin
        // premature load during STREAM must not advance the round
        load_i = 1'b1;
        burst("t2_r", 12'h040, 1, 3'd0);
        load_i = 1'b0;
        burst("t2_r", 12'h041, 2, 3'd0);
      end else begin
        burst("t2_r", 12'h040, 3, 3'(r));
      end
      if (r < 2) begin
        for (int c = 0; c < 5; c++) begin
          step();
          chk("t2_pass_end", end_feature_o, 1);
          chk("t2_pass_nord", feat_rd_en_o, 0);
          chk("t2_pass_round", round_o, 3'(r));
        end
        load_i = 1'b1;
        step();
        load_i = 1'b0;
        chk("t2_load_end_lo", end_feature_o, 0);
        chk("t2_load_round", round_o, 3'(r + 1));
        chk("t2_load_nord", feat_rd_en_o, 0);
      end
    end
    rd_feature_ld_i = 1'b0;
    hold_and_done("t2");
    chk("t2_idle_round", round_o, 0);

    // ---- gapped requests 1,0,1,1,0,1 with 4 features
    start_job(12'h200, 10'd4, 3'd1, 1'b0);
    pat  = 6'b101101;
    nstb = 0;
    for (int k = 5; k >= 0; k--) begin
      rd_feature_ld_i = pat[k];
      step();
      chk("t3_strobe", feat_rd_en_o, pat[k]);
      if (pat[k]) begin
        a = 12'h200 + 12'(nstb);
        chk("t3_addr", feat_addrs_o, a);
        nstb++;
      end
    end
    chk("t3_count", nstb, 4);
    rd_feature_ld_i = 1'b0;
    hold_and_done("t3");

    // ---- address wrap
    start_job(12'hFFE, 10'd4, 3'd1, 1'b1);
    burst("t4", 12'hFFE, 4, 3'd0);
    rd_feature_ld_i = 1'b0;
    hold_and_done("t4");

    // ---- degenerate jobs
    start_job(12'h123, 10'd0, 3'd2, 1'b1);
    chk("t5_num0_done", done_o, 1);
    chk("t5_num0_busy", busy_o, 0);
    chk("t5_num0_ready", cfg_ready_o, 1);
    step();
    chk("t5_num0_pulse", done_o, 0);
    chk("t5_num0_nord", feat_rd_en_o, 0);
    start_job(12'h123, 10'd5, 3'd0, 1'b1);
    chk("t5_rnd0_done", done_o, 1);
    step();
    chk("t5_rnd0_nord", feat_rd_en_o, 0);
    chk("t5_rnd0_busy", busy_o, 0);
    rd_feature_ld_i = 1'b0;

    // ---- reset in the middle of a stream
    start_job(12'h300, 10'd8, 3'd2, 1'b1);
    burst("t6", 12'h300, 2, 3'd0);
    rst_ni = 1'b0;
    step();
    chk("t6_rst_rd_en", feat_rd_en_o, 0);
    chk("t6_rst_addr", feat_addrs_o, 0);
    chk("t6_rst_busy", busy_o, 0);
    chk("t6_rst_ready", cfg_ready_o, 0);
    chk("t6_rst_round", round_o, 0);
    chk("t6_rst_end", end_feature_o, 0);
    rst_ni = 1'b1;
    rd_feature_ld_i = 1'b0;
    step();
    chk("t6_post_ready", cfg_ready_o, 1);
    chk("t6_post_busy", busy_o, 0);
    chk("t6_post_rd_en", feat_rd_en_o, 0);

`ifdef FEAT_FETCH_STRIDE_EN
    // ---- strided addresses
    cfg_stride_i = 12'd3;
    start_job(12'h100, 10'd3, 3'd1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step();
      a = 12'h100 + 12'(3 * i);
      chk("t7_rd_en", feat_rd_en_o, 1);
      chk("t7_addr", feat_addrs_o, a);
    end
    rd_feature_ld_i = 1'b0;
    hold_and_done("t7");
    cfg_stride_i = 12'd1;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
